// File: rtl/song_sequencer.sv
// song_sequencer: plays a stored 32-entry note list onto the one-hot key bus.
// Each entry is {note[8:4], len[3:0]}. Notes 0-15 drive a key, 16-30 are rests,
// and 31 ends the song. Timing is counted in ticks of TICK_DIV clock cycles.
module song_sequencer #(
   parameter int TICK_DIV  = 3_125_000,
   parameter int GAP_TICKS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [8:0]  wr_data,
   output logic [15:0] key_out,
   output logic        busy,
   output logic [4:0]  step,
   output logic        done
);

   localparam int TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int REM_MAX = (GAP_TICKS > 16) ? GAP_TICKS : 16;
   localparam int REM_W   = $clog2(REM_MAX + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
   localparam logic [REM_W-1:0]  REM_ONE   = REM_W'(1);
   localparam logic [REM_W-1:0]  REM_FULL  = REM_W'(16);
   localparam logic [REM_W-1:0]  REM_GAP   = REM_W'(GAP_TICKS);
   localparam logic [4:0]        NOTE_END  = 5'd31;
   localparam logic [4:0]        LAST_STEP = 5'd31;
   localparam logic              GAP_NONE  = (GAP_TICKS == 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_NOTE   = 3'd3,
      ST_GAP    = 3'd4
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   state_t             fsm_nxt_s;
   state_t             adv_state_s;

   logic [8:0]         mem_r [0:31];
   logic [8:0]         rd_data_r;

   logic [TICK_W-1:0]  tick_cnt_r;
   logic [TICK_W-1:0]  tick_nxt_s;
   logic [REM_W-1:0]   rem_r;
   logic [REM_W-1:0]   rem_nxt_s;

   logic [15:0]        key_r;
   logic [15:0]        key_raw_s;
   logic [15:0]        key_nxt_s;
   logic               busy_r;
   logic               busy_nxt_s;
   logic [4:0]         step_r;
   logic [4:0]         step_raw_s;
   logic [4:0]         step_nxt_s;
   logic               done_r;
   logic               done_raw_s;
   logic               done_nxt_s;

   logic [4:0]         entry_note_s;
   logic [3:0]         entry_len_s;
   logic               entry_end_s;
   logic               end_restart_s;
   logic               tick_wrap_s;
   logic               last_tick_s;
   logic               adv_finish_s;
   logic [4:0]         adv_step_s;

   // Decode the fetched entry and derive the tick/advance decisions used by both FSM processes.
   always_comb begin
      entry_note_s  = rd_data_r[8:4];
      entry_len_s   = rd_data_r[3:0];
      entry_end_s   = (entry_note_s == NOTE_END);
      end_restart_s = loop && (step_r != 5'd0);
      tick_wrap_s   = (tick_cnt_r == TICK_LAST);
      last_tick_s   = tick_wrap_s && (rem_r == REM_ONE);
      adv_finish_s  = (step_r == LAST_STEP) && !loop;
      adv_step_s    = adv_finish_s ? step_r : (step_r + 5'd1);
      adv_state_s   = adv_finish_s ? ST_IDLE : ST_FETCH;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; stop overrides every transition.
   always_comb begin
      fsm_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               fsm_nxt_s = ST_FETCH;
            end else begin
               fsm_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            fsm_nxt_s = ST_DECODE;
         end
         ST_DECODE: begin
            if (entry_end_s) begin
               if (end_restart_s) begin
                  fsm_nxt_s = ST_FETCH;
               end else begin
                  fsm_nxt_s = ST_IDLE;
               end
            end else begin
               fsm_nxt_s = ST_NOTE;
            end
         end
         ST_NOTE: begin
            if (last_tick_s) begin
               if (GAP_NONE) begin
                  fsm_nxt_s = adv_state_s;
               end else begin
                  fsm_nxt_s = ST_GAP;
               end
            end else begin
               fsm_nxt_s = ST_NOTE;
            end
         end
         ST_GAP: begin
            if (last_tick_s) begin
               fsm_nxt_s = adv_state_s;
            end else begin
               fsm_nxt_s = ST_GAP;
            end
         end
         default: begin
            fsm_nxt_s = ST_IDLE;
         end
      endcase
      state_nxt_s = stop ? ST_IDLE : fsm_nxt_s;
   end

   // Output and counter next values; stop silences the key and suppresses done but keeps step.
   always_comb begin
      step_raw_s = step_r;
      key_raw_s  = 16'h0000;
      done_raw_s = 1'b0;
      tick_nxt_s = tick_cnt_r;
      rem_nxt_s  = rem_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               step_raw_s = 5'd0;
            end else begin
               step_raw_s = step_r;
            end
         end
         ST_FETCH: begin
            key_raw_s = 16'h0000;
         end
         ST_DECODE: begin
            if (entry_end_s) begin
               if (end_restart_s) begin
                  step_raw_s = 5'd0;
               end else begin
                  done_raw_s = 1'b1;
               end
            end else begin
               key_raw_s  = entry_note_s[4] ? 16'h0000 : (16'h0001 << entry_note_s[3:0]);
               rem_nxt_s  = (entry_len_s == 4'd0) ? REM_FULL : REM_W'(entry_len_s);
               tick_nxt_s = TICK_ZERO;
            end
         end
         ST_NOTE, ST_GAP: begin
            if (tick_wrap_s) begin
               tick_nxt_s = TICK_ZERO;
               rem_nxt_s  = rem_r - REM_ONE;
            end else begin
               tick_nxt_s = tick_cnt_r + TICK_ONE;
               rem_nxt_s  = rem_r;
            end
            if (last_tick_s) begin
               key_raw_s = 16'h0000;
               if ((state_r == ST_NOTE) && !GAP_NONE) begin
                  rem_nxt_s = REM_GAP;
               end else begin
                  step_raw_s = adv_step_s;
                  done_raw_s = adv_finish_s;
               end
            end else begin
               key_raw_s = (state_r == ST_NOTE) ? key_r : 16'h0000;
            end
         end
         default: begin
            key_raw_s = 16'h0000;
         end
      endcase
      key_nxt_s  = stop ? 16'h0000 : key_raw_s;
      done_nxt_s = stop ? 1'b0 : done_raw_s;
      step_nxt_s = stop ? step_r : step_raw_s;
      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // Registered outputs and tick/remaining counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_r      <= 16'h0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         step_r     <= 5'd0;
         tick_cnt_r <= TICK_ZERO;
         rem_r      <= {REM_W{1'b0}};
      end else begin
         key_r      <= key_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         step_r     <= step_nxt_s;
         tick_cnt_r <= tick_nxt_s;
         rem_r      <= rem_nxt_s;
      end
   end

   // Note storage: writes are only accepted while idle; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en && (state_r == ST_IDLE)) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read of the current entry; the value fetched in FETCH is used in DECODE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_r <= 9'h000;
      end else begin
         rd_data_r <= mem_r[step_r];
      end
   end

   assign key_out = key_r;
   assign busy    = busy_r;
   assign step    = step_r;
   assign done    = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer: builds an expected per-cycle timeline from the
// song contents (durations, gaps, END/loop rules) and compares every cycle.
module tb_song_sequencer;

   localparam int TD  = 4;
   localparam int GAP = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = 5'd0;
   logic [8:0]  wr_data = 9'd0;
   logic [15:0] key_out;
   logic        busy;
   logic [4:0]  step;
   logic        done;

   song_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .key_out(key_out), .busy(busy), .step(step), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] key;
      logic        busy;
      logic        done;
      logic [4:0]  step;
   } exp_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [8:0]  mem_m [32];
   logic [4:0]  m_step = 5'd0;
   exp_t        q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic loop_at(input logic loop_init, input int drop_edge, input int e);
      return loop_init && ((drop_edge < 0) || (e < drop_edge));
   endfunction

   task automatic push(input logic [15:0] k, input logic b, input logic d, input logic [4:0] s);
      exp_t x;
      x.key = k; x.busy = b; x.done = d; x.step = s;
      q.push_back(x);
   endtask

   // q[j] = outputs seen after the j-th edge following the start edge (edge 0).
   task automatic build(input logic loop_init, input int drop_edge, input int limit);
      int s;
      bit fin;
      s = 0;
      fin = 1'b0;
      q.delete();
      while (!fin && (q.size() < limit)) begin
         logic [4:0]  note;
         int          len;
         logic [15:0] k;
         push(16'h0000, 1'b1, 1'b0, 5'(s));   // fetch
         push(16'h0000, 1'b1, 1'b0, 5'(s));   // decode
         note = mem_m[s][8:4];
         len  = int'(mem_m[s][3:0]);
         if (len == 0) len = 16;
         if (note == 5'd31) begin
            if (loop_at(loop_init, drop_edge, q.size()) && (s != 0)) begin
               s = 0;
            end else begin
               push(16'h0000, 1'b0, 1'b1, 5'(s));
               fin = 1'b1;
            end
         end else begin
            k = (note < 5'd16) ? (16'h0001 << note[3:0]) : 16'h0000;
            for (int i = 0; i < len * TD; i++) push(k, 1'b1, 1'b0, 5'(s));
            for (int i = 0; i < GAP * TD; i++) push(16'h0000, 1'b1, 1'b0, 5'(s));
            if (s == 31) begin
               if (loop_at(loop_init, drop_edge, q.size())) begin
                  s = 0;
               end else begin
                  push(16'h0000, 1'b0, 1'b1, 5'(s));
                  fin = 1'b1;
               end
            end else begin
               s++;
            end
         end
      end
      if (fin) begin
         push(16'h0000, 1'b0, 1'b0, 5'(s));
         push(16'h0000, 1'b0, 1'b0, 5'(s));
      end
   endtask

   task automatic wr_mem(input logic [4:0] a, input logic [8:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   // abort_edge: edge at which stop (or reset if abort_rst) is applied, -1 for none.
   task automatic play(input string name, input logic loop_init, input int drop_edge,
                       input int abort_edge, input bit abort_rst, input int extra_start_edge,
                       input int busy_wr_edge, input bit ws, input logic [4:0] ws_a,
                       input logic [8:0] ws_d);
      logic [4:0] s_keep;
      if (ws) mem_m[ws_a] = ws_d;
      build(loop_init, drop_edge, (abort_edge >= 0) ? abort_edge + 1 : 30000);
      if ((abort_edge >= 0) && (q.size() > abort_edge)) begin
         if (abort_rst) s_keep = 5'd0;
         else if (abort_edge == 0) s_keep = m_step;
         else s_keep = q[abort_edge - 1].step;
         while (q.size() > abort_edge) void'(q.pop_back());
         for (int i = 0; i < 3; i++) push(16'h0000, 1'b0, 1'b0, s_keep);
      end
      loop  = loop_at(loop_init, drop_edge, 0);
      start = 1'b1;
      stop  = (abort_edge == 0) && !abort_rst;
      if (ws) begin
         wr_en = 1'b1; wr_addr = ws_a; wr_data = ws_d;
      end
      for (int j = 0; j < q.size(); j++) begin
         @(posedge clk); #1;
         start = 1'b0; stop = 1'b0; wr_en = 1'b0; rst_n = 1'b1;
         check($sformatf("%s[%0d] key", name, j), {16'h0000, key_out}, {16'h0000, q[j].key});
         check($sformatf("%s[%0d] busy", name, j), {31'd0, busy}, {31'd0, q[j].busy});
         check($sformatf("%s[%0d] done", name, j), {31'd0, done}, {31'd0, q[j].done});
         check($sformatf("%s[%0d] step", name, j), {27'd0, step}, {27'd0, q[j].step});
         loop  = loop_at(loop_init, drop_edge, j + 1);
         stop  = ((j + 1) == abort_edge) && !abort_rst;
         rst_n = !(((j + 1) == abort_edge) && abort_rst);
         start = ((j + 1) == extra_start_edge);
         if ((j + 1) == busy_wr_edge) begin
            wr_en = 1'b1; wr_addr = 5'd1; wr_data = 9'h0A5;
         end
      end
      start = 1'b0; stop = 1'b0; wr_en = 1'b0; rst_n = 1'b1;
      m_step = q[q.size() - 1].step;
   endtask

   initial begin
      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset key", {16'h0000, key_out}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset step", {27'd0, step}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) wr_mem(5'(i), 9'h1F0);

      // single note: note 2 len 3, then END
      wr_mem(5'd0, 9'h023); wr_mem(5'd1, 9'h1F0);
      play("single", 1'b0, -1, -1, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);
      check("single final step", {27'd0, step}, 32'd1);

      // rest then len 0 note
      wr_mem(5'd0, 9'h102); wr_mem(5'd1, 9'h0F0); wr_mem(5'd2, 9'h1F0);
      play("restlen0", 1'b0, -1, -1, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);

      // loop, then drop loop
      wr_mem(5'd0, 9'h001); wr_mem(5'd1, 9'h011); wr_mem(5'd2, 9'h1F0);
      play("loop", 1'b1, 150, -1, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);

      // stop on the 5th cycle of a note, then start+stop from idle
      wr_mem(5'd0, 9'h023); wr_mem(5'd1, 9'h1F0);
      play("stopnote", 1'b0, -1, 7, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);
      play("startstop", 1'b0, -1, 0, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);

      // full memory, no END, with and without loop
      for (int i = 0; i < 32; i++) wr_mem(5'(i), 9'h031);
      play("full", 1'b0, -1, -1, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);
      check("full final step", {27'd0, step}, 32'd31);
      play("fullloop", 1'b1, 400, -1, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);

      // END at entry 0 with loop set must not spin
      wr_mem(5'd0, 9'h1F0);
      play("end0loop", 1'b1, -1, -1, 1'b0, -1, -1, 1'b0, 5'd0, 9'd0);

      // ignored write while busy, ignored start while busy, write together with start
      wr_mem(5'd1, 9'h052); wr_mem(5'd2, 9'h1F0);
      play("busywr", 1'b0, -1, -1, 1'b0, -1, 5, 1'b1, 5'd0, 9'h023);
      play("busystart", 1'b0, -1, -1, 1'b0, 8, -1, 1'b0, 5'd0, 9'd0);
      play("wrstart", 1'b0, -1, -1, 1'b0, -1, -1, 1'b1, 5'd0, 9'h0E2);

      // reset mid-note
      play("rstnote", 1'b0, -1, 6, 1'b1, -1, -1, 1'b0, 5'd0, 9'd0);

      // randomized songs
      for (int t = 0; t < 20; t++) begin
         int   n;
         logic lp;
         int   drop;
         int   ab;
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++)
            wr_mem(5'(i), {5'($urandom_range(0, 30)), 4'($urandom_range(0, 15))});
         wr_mem(5'(n), 9'h1F0);
         lp   = 1'($urandom_range(0, 1));
         drop = $urandom_range(0, 300);
         ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1;
         play($sformatf("rand%0d", t), lp, drop, ab, 1'($urandom_range(0, 1)), -1, -1,
              1'b0, 5'd0, 9'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
